// File: rtl/lcd_pkg.sv
// Shared types, pin indices and command constants for the HD44780-class LCD engine.
// Used by lcd_fifo and lcd_ctrl; the init ROM only matters when LCD_INIT_EN is defined.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    localparam int LCD_E  = 10;
    localparam int LCD_RS = 9;
    localparam int LCD_RW = 8;

    localparam int CNT_W = 20;

    // Commands that need the long execution wait on the panel.
    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_HOME_ALT = 8'h03;

    localparam logic [7:0] INIT_FUNC_SET = 8'h38;
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
    localparam logic [7:0] INIT_ENTRY    = 8'h06;

    function automatic logic [CNT_W-1:0] phase_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

    function automatic logic is_slow_cmd(input lcd_entry_t e);
        return !e.rs && ((e.data == OP_CLEAR) || (e.data == OP_HOME) ||
                         (e.data == OP_HOME_ALT));
    endfunction

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] op;
        case (idx)
            2'd0:    op = INIT_FUNC_SET;
            2'd1:    op = INIT_DISP_ON;
            2'd2:    op = INIT_ENTRY;
            default: op = OP_CLEAR;
        endcase
        return op;
    endfunction

    function automatic logic [10:0] lcd_pins(input lcd_entry_t e, input logic en);
        logic [10:0] p;
        p         = '0;
        p[LCD_E]  = en;
        p[LCD_RS] = e.rs;
        p[LCD_RW] = 1'b0;
        p[7:0]    = e.data;
        return p;
    endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Synchronous FIFO of {rs, data} entries between the CPU write port and the LCD engine.
// empty_o is registered, so a freshly written entry is seen by the reader one cycle later.
module lcd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  lcd_entry_t              data_i,
    input  logic                    pop_i,
    output lcd_entry_t              data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    lcd_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = empty_q;
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_q == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/lcd_ctrl.sv
// Character-LCD interface engine: queues CPU byte writes and replays them with HD44780 timing.
// Define LCD_INIT_EN to add the power-up wait and the built-in init command sequence.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int T_SETUP    = 4,
    parameter int T_EPW      = 16,
    parameter int T_HOLD     = 2,
    parameter int T_CMD      = 2500,
    parameter int T_CLR      = 103000
`ifdef LCD_INIT_EN
    ,
    parameter int T_PWRUP    = 938000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        wr_rs,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        ready,
    output logic        ovf,
    output logic [10:0] lcd
);

`ifdef LCD_INIT_EN
    localparam lcd_state_e RESET_STATE = PWRUP;
`else
    localparam lcd_state_e RESET_STATE = IDLE;
`endif

    lcd_state_e                  state_q;
    logic [CNT_W-1:0]            cnt_q;
    lcd_entry_t                  cur_q;
    logic [10:0]                 lcd_q;
    logic                        ovf_q;
    lcd_entry_t                  fifo_head;
    lcd_entry_t                  issue;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef LCD_INIT_EN
    logic [1:0]                  rom_idx_q;
    logic                        init_done_q;
`endif

    lcd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (wr_en),
        .data_i  ({wr_rs, wr_data}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fifo_pop = (state_q == IDLE) && !fifo_empty;
    assign full     = fifo_full;
    assign ovf      = ovf_q;
    assign lcd      = lcd_q;
`ifdef LCD_INIT_EN
    assign ready    = (state_q == IDLE) && (fifo_count == '0) && init_done_q;
`else
    assign ready    = (state_q == IDLE) && (fifo_count == '0);
`endif

    // The byte about to enter SETUP comes from the init ROM while initialising, else the FIFO.
    always_comb begin
        issue = fifo_head;
`ifdef LCD_INIT_EN
        if (state_q == INIT) issue = {1'b0, init_rom(rom_idx_q)};
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr_en && fifo_full) begin
            ovf_q <= 1'b1;
        end
    end

    // Pins are registered with the state so E changes exactly on phase boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            cur_q   <= '0;
            lcd_q   <= '0;
`ifdef LCD_INIT_EN
            rom_idx_q   <= '0;
            init_done_q <= 1'b0;
`endif
        end else begin
            case (state_q)
`ifdef LCD_INIT_EN
                // Counts up from the reset value of 0 so the power-up wait is T_PWRUP cycles.
                PWRUP: begin
                    if (cnt_q == phase_load(T_PWRUP)) begin
                        cnt_q   <= '0;
                        state_q <= INIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                INIT: begin
                    cur_q     <= issue;
                    lcd_q     <= lcd_pins(issue, 1'b0);
                    cnt_q     <= phase_load(T_SETUP);
                    state_q   <= SETUP;
                    rom_idx_q <= rom_idx_q + 1'b1;
                    if (rom_idx_q == 2'd3) init_done_q <= 1'b1;
                end
`endif
                IDLE: begin
                    if (!fifo_empty) begin
                        cur_q   <= issue;
                        lcd_q   <= lcd_pins(issue, 1'b0);
                        cnt_q   <= phase_load(T_SETUP);
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        lcd_q[LCD_E] <= 1'b1;
                        cnt_q        <= phase_load(T_EPW);
                        state_q      <= PULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        lcd_q[LCD_E] <= 1'b0;
                        cnt_q        <= phase_load(T_HOLD);
                        state_q      <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= is_slow_cmd(cur_q) ? phase_load(T_CLR) : phase_load(T_CMD);
                        state_q <= WAIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
                        state_q <= init_done_q ? IDLE : INIT;
`else
                        state_q <= IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing (T_SETUP=2, T_EPW=4, T_HOLD=1, T_CMD=20, T_CLR=100).
// With LCD_INIT_EN defined it also checks the power-up wait and init command sequence.
module tb_lcd_ctrl;

    localparam int T_SETUP = 2;
    localparam int T_EPW   = 4;
    localparam int T_HOLD  = 1;
    localparam int T_CMD   = 20;
    localparam int T_CLR   = 100;
`ifdef LCD_INIT_EN
    localparam int T_PWRUP = 50;
`endif

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        wr_en   = 1'b0;
    logic        wr_rs   = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        full;
    logic        ready;
    logic        ovf;
    logic [10:0] lcd;

    int n_cmp = 0;
    int n_bad = 0;

    lcd_ctrl #(
        .FIFO_DEPTH (8),
        .T_SETUP    (T_SETUP),
        .T_EPW      (T_EPW),
        .T_HOLD     (T_HOLD),
        .T_CMD      (T_CMD),
        .T_CLR      (T_CLR)
`ifdef LCD_INIT_EN
        ,
        .T_PWRUP    (T_PWRUP)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_rs   (wr_rs),
        .wr_data (wr_data),
        .full    (full),
        .ready   (ready),
        .ovf     (ovf),
        .lcd     (lcd)
    );

    always #5 clk = ~clk;

    // One-cycle write strobe; returns 1 time unit after the edge that sampled it.
    task automatic drive_write(input logic rs, input logic [7:0] d);
        wr_rs   = rs;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef LCD_INIT_EN
        for (int i = 0; i < 400 && ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL init_wait: ready=%b expected 1", ready);
        end
`endif
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 400 && ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL %s_ready: ready=%b expected 1", tag, ready);
        end
    endtask

    // Cycles from the end of one E pulse to the start of the next, plus the pins at that start.
    task automatic measure_gap(output int gap, output logic [9:0] pins2);
        int k;
        gap   = -1;
        pins2 = '0;
        k = 0;
        while (lcd[10] !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
        k = 0;
        while (lcd[10] !== 1'b0 && k < 200) begin @(posedge clk); #1; k++; end
        k = 0;
        while (lcd[10] !== 1'b1 && k < 500) begin @(posedge clk); #1; k++; end
        if (lcd[10] === 1'b1) begin
            gap   = k;
            pins2 = lcd[9:0];
        end
    endtask

    task automatic test_reset();
        logic exp_ready;
`ifdef LCD_INIT_EN
        exp_ready = 1'b0;
`else
        exp_ready = 1'b1;
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (lcd !== 11'h000) begin
            n_bad++;
            $display("[TB] FAIL reset_lcd: got %h expected 000", lcd);
        end
        n_cmp++;
        if (full !== 1'b0 || ovf !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_flags: full=%b ovf=%b expected 0 0", full, ovf);
        end
        n_cmp++;
        if (ready !== exp_ready) begin
            n_bad++;
            $display("[TB] FAIL reset_ready: got %b expected %b", ready, exp_ready);
        end
    endtask

    // Write at edge N: pins at N+2, E high N+4..N+7, ready back at N+29.
    task automatic test_single_write();
        int e_first;
        int e_cnt;
        e_first = -1;
        e_cnt   = 0;
        do_reset();
        drive_write(1'b1, 8'h41);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                n_cmp++;
                if (lcd[7:0] === 8'h41) begin
                    n_bad++;
                    $display("[TB] FAIL single_early: DB=%h already at N+1", lcd[7:0]);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (lcd !== {1'b0, 1'b1, 1'b0, 8'h41}) begin
                    n_bad++;
                    $display("[TB] FAIL single_pins: got %h expected 241", lcd);
                end
            end
            if (lcd[10] === 1'b1) begin
                if (e_first < 0) e_first = k;
                e_cnt++;
            end
            if (k == 28) begin
                n_cmp++;
                if (ready !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL single_ready_early: got %b expected 0", ready);
                end
            end
            if (k == 29) begin
                n_cmp++;
                if (ready !== 1'b1) begin
                    n_bad++;
                    $display("[TB] FAIL single_ready: got %b expected 1", ready);
                end
            end
        end
        n_cmp++;
        if (e_first != 4) begin
            n_bad++;
            $display("[TB] FAIL single_e_start: got N+%0d expected N+4", e_first);
        end
        n_cmp++;
        if (e_cnt != 4) begin
            n_bad++;
            $display("[TB] FAIL single_e_width: got %0d expected 4", e_cnt);
        end
        n_cmp++;
        if (lcd[8] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL single_rw: got %b expected 0", lcd[8]);
        end
    endtask

    // Gap between E pulses is wait + T_HOLD + IDLE + T_SETUP = wait + 4.
    task automatic test_clear_timing();
        logic       rs_tab  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] op_tab  [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 8'h01};
        int         gap_tab [6] = '{104, 104, 104, 24, 24, 24};
        int         gap;
        logic [9:0] pins2;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_write(rs_tab[i], op_tab[i]);
            drive_write(1'b1, 8'h42 + 8'(i));
            measure_gap(gap, pins2);
            n_cmp++;
            if (gap != gap_tab[i]) begin
                n_bad++;
                $display("[TB] FAIL gap_op%0d_rs%0d: got %0d expected %0d",
                         op_tab[i], rs_tab[i], gap, gap_tab[i]);
            end
            n_cmp++;
            if (pins2 !== {1'b1, 1'b0, 8'h42 + 8'(i)}) begin
                n_bad++;
                $display("[TB] FAIL gap_pins%0d: got %h expected %h",
                         i, pins2, {1'b1, 1'b0, 8'h42 + 8'(i)});
            end
            wait_ready("gap");
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got [16];
        int         got_n;
        logic       prev_e;
        do_reset();
        drive_write(1'b1, 8'h55);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            drive_write(1'b1, 8'hA0 + 8'(i));
            if (i == 6) begin
                n_cmp++;
                if (full !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL full_after7: got %b expected 0", full);
                end
            end
            if (i == 7) begin
                n_cmp++;
                if (full !== 1'b1 || ovf !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL full_after8: full=%b ovf=%b expected 1 0", full, ovf);
                end
            end
        end
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL ovf_set: got %b expected 1", ovf);
        end
        got_n  = 0;
        prev_e = lcd[10];
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (lcd[10] === 1'b1 && prev_e !== 1'b1) begin
                if (got_n < 16) got[got_n] = lcd[7:0];
                got_n++;
            end
            prev_e = lcd[10];
        end
        n_cmp++;
        if (got_n != 8) begin
            n_bad++;
            $display("[TB] FAIL ovf_count: got %0d bytes expected 8", got_n);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] !== 8'hA0 + 8'(i)) begin
                n_bad++;
                $display("[TB] FAIL ovf_order%0d: got %h expected %h", i, got[i], 8'hA0 + 8'(i));
            end
        end
        n_cmp++;
        if (ovf !== 1'b1 || full !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ovf_sticky: ovf=%b full=%b expected 1 0", ovf, full);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int   k;
        int   stale;
        logic prev_e;
        do_reset();
        drive_write(1'b1, 8'h61);
        drive_write(1'b1, 8'h62);
        k = 0;
        while (lcd[10] !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
        n_cmp++;
        if (lcd[10] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL midrst_pulse: E=%b expected 1", lcd[10]);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (lcd !== 11'h000) begin
            n_bad++;
            $display("[TB] FAIL midrst_async: got %h expected 000", lcd);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        stale  = 0;
        prev_e = lcd[10];
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (lcd[10] === 1'b1 && prev_e !== 1'b1 && lcd[9] === 1'b1) stale++;
            prev_e = lcd[10];
        end
        n_cmp++;
        if (stale != 0) begin
            n_bad++;
            $display("[TB] FAIL midrst_stale: got %0d data pulses expected 0", stale);
        end
        wait_ready("midrst");
    endtask

`ifdef LCD_INIT_EN
    // PWRUP ends at edge 50; E rises at 53, 81, 109, 137; ready at 242.
    task automatic test_init();
        int         rise_k  [4] = '{53, 81, 109, 137};
        logic [7:0] rise_op [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        int         n;
        logic       prev_e;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        n      = 0;
        prev_e = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            @(posedge clk);
            #1;
            if (lcd[10] === 1'b1 && prev_e !== 1'b1) begin
                n_cmp++;
                if (n >= 4 || k != rise_k[n] || lcd[9:0] !== {2'b00, rise_op[n]}) begin
                    n_bad++;
                    $display("[TB] FAIL init_cmd%0d: at %0d pins %h", n, k, lcd[9:0]);
                end
                n++;
            end
            prev_e = lcd[10];
            if (k == 241) begin
                n_cmp++;
                if (ready !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL init_ready_early: got %b expected 0", ready);
                end
            end
            if (k == 242) begin
                n_cmp++;
                if (ready !== 1'b1) begin
                    n_bad++;
                    $display("[TB] FAIL init_ready: got %b expected 1", ready);
                end
            end
        end
        n_cmp++;
        if (n != 4) begin
            n_bad++;
            $display("[TB] FAIL init_count: got %0d expected 4", n);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_clear_timing();
        test_overflow();
        test_reset_mid_pulse();
`ifdef LCD_INIT_EN
        test_init();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
